// File: rtl/seq_hit_counter_if.sv
// seq_hit_counter_if: detector hit/clear inputs and count/LED/segment outputs
interface seq_hit_counter_if;
  logic       hit;
  logic       clr;
  logic [7:0] count_bcd;
  logic       overflow;
  logic       led;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  modport master (output hit, clr, input count_bcd, overflow, led, seg_tens, seg_ones);
  modport slave (input hit, clr, output count_bcd, overflow, led, seg_tens, seg_ones);
endinterface

// File: rtl/seq_hit_counter.sv
// seq_hit_counter: BCD hit counter with stretched LED pulse and 7-segment display
module seq_hit_counter #(
  parameter int STRETCH_CYCLES = 12_000_000,
  parameter bit SATURATE = 1'b0
) (
  input logic clk,
  input logic rst_n,
  seq_hit_counter_if.slave bus
);
  localparam int SW = $clog2(STRETCH_CYCLES);
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYCLES - 1);
  logic hit_q, ev, at_max, ovf, led;
  logic [3:0] ones, tens, ones_n, tens_n;
  logic [SW-1:0] str;
  logic [6:0] seg_t, seg_o;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  assign ev = bus.hit & ~hit_q;
  assign at_max = (tens == 4'd9) && (ones == 4'd9);
  // next BCD value; 99 rolls to 00, saturation is applied at the register
  always_comb begin
    ones_n = (ones == 4'd9) ? 4'd0 : ones + 4'd1;
    tens_n = (ones != 4'd9) ? tens : (tens == 4'd9) ? 4'd0 : tens + 4'd1;
  end
  // hit history keeps sampling through clr so a held hit is not recounted
  always_ff @(posedge clk)
    hit_q <= rst_n ? bus.hit : 1'b0;
  // count and sticky overflow; clr discards a same-cycle event
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
      ovf  <= 1'b0;
    end else if (ev) begin
      if (!(SATURATE && at_max)) begin
        tens <= tens_n;
        ones <= ones_n;
      end
      if (at_max) ovf <= 1'b1;
    end
  end
  // LED stretch: reload on each event, led lags the counter by one so it lasts STRETCH_CYCLES
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      str <= '0;
      led <= 1'b0;
    end else if (ev) begin
      str <= RELOAD;
      led <= 1'b1;
    end else begin
      str <= (str != '0) ? str - 1'b1 : str;
      led <= str != '0;
    end
  end
  // registered segment decode with leading-zero blanking on the tens digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_t <= 7'b1111111;
      seg_o <= 7'b1000000;
    end else begin
      seg_t <= (tens == 4'd0) ? 7'b1111111 : seg7(tens);
      seg_o <= seg7(ones);
    end
  end
  assign bus.count_bcd = {tens, ones};
  assign bus.overflow  = ovf;
  assign bus.led       = led;
  assign bus.seg_tens  = seg_t;
  assign bus.seg_ones  = seg_o;
endmodule

// File: tb/tb_seq_hit_counter.sv
// tb_seq_hit_counter: directed table and sequences for wrap and saturate variants
module tb_seq_hit_counter;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  seq_hit_counter_if w_if ();
  seq_hit_counter_if s_if ();
  seq_hit_counter #(.STRETCH_CYCLES(4), .SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(w_if.slave));
  seq_hit_counter #(.STRETCH_CYCLES(4), .SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic       hit;
    logic       clr;
    logic [7:0] cnt;
    logic       led;
    logic       ovf;
    logic [6:0] so;
  } vec_t;
  vec_t tbl[21];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic h, input logic c);
    w_if.hit = h;
    s_if.hit = h;
    w_if.clr = c;
    s_if.clr = c;
  endtask
  task automatic hits(input int n);
    repeat (n) begin
      @(negedge clk) drive(1'b1, 1'b0);
      @(negedge clk) drive(1'b0, 1'b0);
    end
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 7'h40};
    tbl[1]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 7'h79};
    tbl[2]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 7'h79};
    tbl[3]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 7'h79};
    tbl[4]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 7'h79};
    tbl[5]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 7'h79};
    tbl[6]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 7'h24};
    tbl[7]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 7'h24};
    tbl[8]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 7'h24};
    tbl[9]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 7'h24};
    tbl[10] = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 7'h24};
    tbl[11] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 7'h24};
    tbl[12] = '{1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 7'h30};
    tbl[13] = '{1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 7'h30};
    tbl[14] = '{1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 7'h19};
    tbl[15] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 7'h19};
    tbl[16] = '{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 7'h12};
    tbl[17] = '{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 7'h12};
    tbl[18] = '{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 7'h12};
    tbl[19] = '{1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 7'h12};
    tbl[20] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 7'h12};
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset count", 16'(w_if.count_bcd), 16'h00);
    chk("reset led", 16'(w_if.led), 16'h0);
    chk("reset ovf", 16'(w_if.overflow), 16'h0);
    chk("reset seg_tens", 16'(w_if.seg_tens), 16'h7F);
    chk("reset seg_ones", 16'(w_if.seg_ones), 16'h40);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle count", 16'(w_if.count_bcd), 16'h00);
    chk("idle led", 16'(w_if.led), 16'h0);
    chk("idle ovf", 16'(w_if.overflow), 16'h0);
    chk("idle seg_tens", 16'(w_if.seg_tens), 16'h7F);
    chk("idle seg_ones", 16'(w_if.seg_ones), 16'h40);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk) drive(tbl[i].hit, tbl[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d count", i), 16'(w_if.count_bcd), 16'(tbl[i].cnt));
      chk($sformatf("vec%0d led", i), 16'(w_if.led), 16'(tbl[i].led));
      chk($sformatf("vec%0d ovf", i), 16'(w_if.overflow), 16'(tbl[i].ovf));
      chk($sformatf("vec%0d seg_ones", i), 16'(w_if.seg_ones), 16'(tbl[i].so));
    end
    @(negedge clk) drive(1'b0, 1'b0);
    hits(9);
    chk("nine count", 16'(w_if.count_bcd), 16'h09);
    chk("nine seg_tens blank", 16'(w_if.seg_tens), 16'h7F);
    chk("nine seg_ones", 16'(w_if.seg_ones), 16'h10);
    hits(1);
    chk("ten count", 16'(w_if.count_bcd), 16'h10);
    chk("ten seg_tens", 16'(w_if.seg_tens), 16'h79);
    chk("ten seg_ones", 16'(w_if.seg_ones), 16'h40);
    hits(89);
    chk("99 count", 16'(w_if.count_bcd), 16'h99);
    chk("99 ovf", 16'(w_if.overflow), 16'h0);
    hits(1);
    chk("wrap count", 16'(w_if.count_bcd), 16'h00);
    chk("wrap ovf", 16'(w_if.overflow), 16'h1);
    chk("wrap seg_tens", 16'(w_if.seg_tens), 16'h7F);
    chk("sat count", 16'(s_if.count_bcd), 16'h99);
    chk("sat ovf", 16'(s_if.overflow), 16'h1);
    chk("sat seg_tens", 16'(s_if.seg_tens), 16'h10);
    chk("sat seg_ones", 16'(s_if.seg_ones), 16'h10);
    hits(1);
    chk("post-wrap count", 16'(w_if.count_bcd), 16'h01);
    chk("post-wrap ovf", 16'(w_if.overflow), 16'h1);
    chk("post-sat count", 16'(s_if.count_bcd), 16'h99);
    chk("post-sat ovf", 16'(s_if.overflow), 16'h1);
    hits(41);
    chk("at 42 count", 16'(w_if.count_bcd), 16'h42);
    @(negedge clk) drive(1'b1, 1'b1);
    @(negedge clk) drive(1'b1, 1'b0);
    chk("collide count", 16'(w_if.count_bcd), 16'h00);
    chk("collide led", 16'(w_if.led), 16'h0);
    chk("collide ovf", 16'(w_if.overflow), 16'h0);
    repeat (3) @(negedge clk);
    chk("held through clr count", 16'(w_if.count_bcd), 16'h00);
    chk("held through clr led", 16'(w_if.led), 16'h0);
    chk("clr seg_tens", 16'(w_if.seg_tens), 16'h7F);
    chk("clr seg_ones", 16'(w_if.seg_ones), 16'h40);
    drive(1'b0, 1'b0);
    hits(3);
    @(negedge clk) begin
      rst_n = 1'b0;
      drive(1'b1, 1'b0);
    end
    @(negedge clk);
    chk("midreset count", 16'(w_if.count_bcd), 16'h00);
    chk("midreset led", 16'(w_if.led), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("held across reset count", 16'(w_if.count_bcd), 16'h01);
    chk("held across reset led", 16'(w_if.led), 16'h1);
    drive(1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_hit_counter.md
# seq_hit_counter

Downstream consumer of the serial sequence detector's match output. Counts detector hits in two-digit BCD, stretches each hit into a visible LED pulse, and drives two 7-segment digits with the running count. Sits between the detector's `dout` and the board's LED/segment pins.

## Interface
- `STRETCH_CYCLES`, default 12_000_000: LED on-time per hit in clk cycles (1 s at 12 MHz); legal range ≥ 2.
- `SATURATE`, default 0: 0 means the count wraps 99→00; 1 means the count holds at 99.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `hit`  in  1  detector match output; may be combinational upstream, sampled on clk only.
- `clr`  in  1  synchronous clear, active-high, already debounced upstream.
- `count_bcd`  out  8  {tens[3:0], ones[3:0]}, BCD 00..99.
- `overflow`  out  1  sticky; set when a hit occurs at count 99.
- `led`  out  1  stretched hit indicator, active-high.
- `seg_tens`  out  7  {g,f,e,d,c,b,a}, active-low, tens digit.
- `seg_ones`  out  7  {g,f,e,d,c,b,a}, active-low, ones digit.

## Operation
- Input stage: `hit_q` is registered from `hit`. An event is `hit & ~hit_q` (rising edge). A level held high counts once. The detector produces at most one hit every 2 cycles, so no genuine match is lost.
- BCD counter, per event:
  - If ones < 9: increment ones.
  - Otherwise ones → 0 and tens increments.
  - At 99: with SATURATE=0, count → 00 and overflow ← 1. With SATURATE=1, count stays 99 and overflow ← 1.
  - BCD digits never take the values 10–15.
- Stretch counter, width $clog2(STRETCH_CYCLES):
  - An event loads STRETCH_CYCLES−1.
  - Otherwise the counter decrements while nonzero.
  - `led` = 1 while the stretch counter is active.
  - A retrigger during an active stretch reloads the counter, extending the pulse. The pulse is not doubled.
- Segment decode:
  - Each digit is decoded 0–9 into standard active-low patterns. Example: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Leading-zero blanking: when tens = 0, `seg_tens` = 7'b1111111.
  - `seg_ones` is never blanked; count 00 shows a lone "0".
- Priority, each cycle: `rst_n`=0, then `clr`, then event.
  - `clr` zeroes the count, overflow, the stretch counter and `led`. Any event in the same cycle is discarded.
  - `hit_q` still samples `hit` during `clr`, so a hit held across clr release is not recounted.

## Timing
- Reset (rst_n low at a clk edge):
  - count_bcd = 8'h00, overflow = 0, led = 0, hit_q = 0.
  - seg_tens = 7'b1111111 (blank), seg_ones = 7'b1000000 ("0").
- Mid-operation reset behaves identically to clr and also clears `hit_q`.
- Latency from `hit` rising before edge N:
  - count_bcd, overflow and led update at edge N, one cycle of visibility delay.
  - seg_tens and seg_ones are registered from the new count and update at edge N+1.
- LED duration: led goes high at edge N and stays high for exactly STRETCH_CYCLES cycles, falling at edge N+STRETCH_CYCLES if not retriggered.
- Hits 2 cycles apart (detector pattern 10101…) each produce one increment.
- clr asserted at edge M: all outputs except the segments are cleared at edge M. Segments show blank/"0" from edge M+1.

## Test plan
- Reset then idle: after rst_n release with hit=0 for 20 cycles → count_bcd=00, led=0, overflow=0, seg_tens=7'h7F, seg_ones=7'h40.
- Single and held hit (STRETCH_CYCLES=4): hit high 1 cycle → count=01, led high exactly 4 cycles, seg_ones=7'b1111001 one cycle after count. hit held high 10 cycles → count increments by exactly 1.
- Back-to-back detector pattern: drive the hit stream produced by din=1010101 (hits 2 cycles apart, 3 hits) → count=03. led stays high continuously until 4 cycles after the last hit.
- Digit carry and blanking: 9 hits → count=09, seg_tens blank. 10th hit → count=8'h10, seg_tens=7'b1111001, seg_ones=7'b1000000.
- Wrap vs saturate: with SATURATE=0, 100 hits → count=00, overflow=1; further hit → 01 with overflow still 1. With SATURATE=1, 100 hits → count=99, overflow=1.
- Clear collision: clr and a hit edge in the same cycle at count=42 → count=00, led=0, overflow=0. hit held high through clr release → no increment.
